// File: rtl/loteria_registro.sv
// Lottery bet entry stage: captures the draw and up to MAX_JOGOS games, then streams them to the checker.
// Optional duplicate rejection within a group is enabled by defining LOTERIA_DUPLICADO_EN.
module loteria_registro #(
    parameter int MAX_JOGOS     = 5,
    parameter int NUMS_POR_JOGO = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  numero,
    input  logic        insere,
    input  logic        fim,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_numero,
    output logic        out_fim_jogo,
    output logic [15:0] sorteio,
    output logic        sorteio_ok,
    output logic [2:0]  jogos,
    output logic        erro,
    output logic        ocupado,
    output logic        concluido
);

    typedef enum logic [1:0] {S_SORTEIO, S_APOSTA, S_ENVIO, S_FIM} state_t;

    localparam logic [1:0] LAST_POS = 2'(NUMS_POR_JOGO - 1);
    localparam logic [2:0] MAX_J    = 3'(MAX_JOGOS);

    state_t state, state_nxt;

    logic [1:0] sort_pos, wr_pos, rd_pos;
    logic [2:0] rd_jogo;
    logic [MAX_JOGOS-1:0][3:0][3:0] game_buf;
    logic [3:0][3:0] rd_game;

    logic dup, erro_nxt, wr_sort, wr_game, drop_parcial, avanca;

`ifdef LOTERIA_DUPLICADO_EN
    logic [3:0][3:0] grupo;
    logic [1:0]      cnt;

    // The write game is always slot `jogos`; entries already in the group sit below cnt.
    always_comb begin
        grupo = '0;
        cnt   = (state == S_SORTEIO) ? sort_pos : wr_pos;
        if (state == S_SORTEIO) begin
            for (int i = 0; i < 4; i++) grupo[i] = sorteio[4*(3-i) +: 4];
        end else begin
            for (int j = 0; j < MAX_JOGOS; j++)
                if (jogos == 3'(j)) grupo = game_buf[j];
        end
        dup = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < int'(cnt) && grupo[i] == numero) dup = 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        rd_game = '0;
        for (int j = 0; j < MAX_JOGOS; j++)
            if (rd_jogo == 3'(j)) rd_game = game_buf[j];
    end

    assign out_valid    = (state == S_ENVIO);
    assign ocupado      = (state == S_ENVIO);
    assign concluido    = (state == S_FIM);
    assign out_numero   = out_valid ? rd_game[rd_pos] : 4'h0;
    assign out_fim_jogo = out_valid && (rd_pos == LAST_POS);

    always_ff @(posedge clock) begin
        if (!reset) state <= S_SORTEIO;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        erro_nxt     = 1'b0;
        wr_sort      = 1'b0;
        wr_game      = 1'b0;
        drop_parcial = 1'b0;
        avanca       = 1'b0;
        case (state)
            S_SORTEIO: begin
                if (fim) begin
                    erro_nxt = 1'b1;
                end else if (insere) begin
                    if (numero != 4'h0 && !dup) begin
                        wr_sort = 1'b1;
                        if (sort_pos == LAST_POS) state_nxt = S_APOSTA;
                    end else begin
                        erro_nxt = 1'b1;
                    end
                end
            end
            S_APOSTA: begin
                // fim takes priority; a simultaneous insere is silently dropped
                if (fim) begin
                    if (jogos == 3'd0) begin
                        erro_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ENVIO;
                        if (wr_pos != 2'd0) begin
                            erro_nxt     = 1'b1;
                            drop_parcial = 1'b1;
                        end
                    end
                end else if (insere) begin
                    if (jogos == MAX_J || numero == 4'h0 || dup) erro_nxt = 1'b1;
                    else                                         wr_game  = 1'b1;
                end
            end
            S_ENVIO: begin
                if (out_ready) begin
                    avanca = 1'b1;
                    if (rd_pos == LAST_POS && rd_jogo == jogos - 3'd1) state_nxt = S_FIM;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            erro       <= 1'b0;
            sorteio    <= 16'h0000;
            sorteio_ok <= 1'b0;
            jogos      <= 3'd0;
            sort_pos   <= 2'd0;
            wr_pos     <= 2'd0;
            rd_pos     <= 2'd0;
            rd_jogo    <= 3'd0;
            game_buf   <= '0;
        end else begin
            erro <= erro_nxt;
            if (wr_sort) begin
                sorteio[{~sort_pos, 2'b00} +: 4] <= numero;
                sort_pos <= sort_pos + 2'd1;
                if (sort_pos == LAST_POS) sorteio_ok <= 1'b1;
            end
            if (wr_game) begin
                for (int j = 0; j < MAX_JOGOS; j++)
                    if (jogos == 3'(j)) game_buf[j][wr_pos] <= numero;
                if (wr_pos == LAST_POS) begin
                    wr_pos <= 2'd0;
                    jogos  <= jogos + 3'd1;
                end else begin
                    wr_pos <= wr_pos + 2'd1;
                end
            end
            // Partial game data is left in the buffer; it lies beyond jogos and is never read.
            if (drop_parcial) wr_pos <= 2'd0;
            if (avanca) begin
                if (rd_pos == LAST_POS) begin
                    rd_pos  <= 2'd0;
                    rd_jogo <= rd_jogo + 3'd1;
                end else begin
                    rd_pos <= rd_pos + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_loteria_registro.sv
// Bench for loteria_registro: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_loteria_registro;

    localparam int MAXJ = 5;
`ifdef LOTERIA_DUPLICADO_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic        clock, reset;
    logic [3:0]  numero;
    logic        insere, fim, out_ready;
    logic        out_valid, out_fim_jogo, sorteio_ok, erro, ocupado, concluido;
    logic [3:0]  out_numero;
    logic [15:0] sorteio;
    logic [2:0]  jogos;

    loteria_registro #(.MAX_JOGOS(MAXJ), .NUMS_POR_JOGO(4)) dut (
        .clock(clock), .reset(reset), .numero(numero), .insere(insere), .fim(fim),
        .out_ready(out_ready), .out_valid(out_valid), .out_numero(out_numero),
        .out_fim_jogo(out_fim_jogo), .sorteio(sorteio), .sorteio_ok(sorteio_ok),
        .jogos(jogos), .erro(erro), .ocupado(ocupado), .concluido(concluido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 draw, 1 betting, 2 streaming, 3 done
    int          m_fase;
    int          m_draw[$];
    int          m_cur[$];
    logic [15:0] m_games[$];
    int          m_stream[$];
    bit          m_erro;
    int          valid_cnt, fimj_cnt;

    function automatic bit contem(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model(input int n, input bit ins, input bit f, input bit rdy, input bit rst);
        m_erro = 1'b0;
        if (!rst) begin
            m_fase = 0;
            m_draw.delete(); m_cur.delete(); m_games.delete(); m_stream.delete();
        end else begin
            case (m_fase)
                0: if (f) m_erro = 1'b1;
                   else if (ins) begin
                       if (n != 0 && !(DUP_EN && contem(m_draw, n))) begin
                           m_draw.push_back(n);
                           if (m_draw.size() == 4) m_fase = 1;
                       end else m_erro = 1'b1;
                   end
                1: if (f) begin
                       if (m_games.size() == 0) m_erro = 1'b1;
                       else begin
                           if (m_cur.size() != 0) begin m_erro = 1'b1; m_cur.delete(); end
                           foreach (m_games[g])
                               for (int p = 0; p < 4; p++)
                                   m_stream.push_back(int'((m_games[g] >> (12 - 4*p)) & 16'hF));
                           m_fase = 2;
                       end
                   end else if (ins) begin
                       if (m_games.size() == MAXJ) m_erro = 1'b1;
                       else if (n != 0 && !(DUP_EN && contem(m_cur, n))) begin
                           m_cur.push_back(n);
                           if (m_cur.size() == 4) begin
                               logic [15:0] w = '0;
                               foreach (m_cur[i]) w = (w << 4) | 16'(m_cur[i]);
                               m_games.push_back(w);
                               m_cur.delete();
                           end
                       end else m_erro = 1'b1;
                   end
                2: if (rdy) begin
                       void'(m_stream.pop_front());
                       if (m_stream.size() == 0) m_fase = 3;
                   end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [3:0] n, input bit ins, input bit f, input bit rdy, input bit rst);
        logic [15:0] es;
        bit ev, efj;
        numero = n; insere = ins; fim = f; out_ready = rdy; reset = rst;
        @(posedge clock); #1;
        model(int'(n), ins, f, rdy, rst);
        es = '0;
        foreach (m_draw[i]) es |= 16'(m_draw[i]) << (12 - 4*i);
        ev  = (m_fase == 2);
        efj = ev && (m_stream.size() % 4 == 1);
        chk("ctrl", 32'({out_valid, out_fim_jogo, sorteio_ok, erro, ocupado, concluido}),
                    32'({ev, efj, m_fase != 0, m_erro, ev, m_fase == 3}));
        chk("sorteio", 32'(sorteio), 32'(es));
        chk("jogos", 32'(jogos), 32'(m_games.size()));
        if (ev) chk("out_numero", 32'(out_numero), 32'(m_stream[0]));
        if (out_valid) valid_cnt++;
        if (out_fim_jogo) fimj_cnt++;
    endtask

    task automatic put(input logic [3:0] n); step(n, 1, 0, 0, 1); endtask
    task automatic idle(input bit rdy);      step(0, 0, 0, rdy, 1); endtask
    task automatic cmd_fim();                step(0, 0, 1, 1, 1); endtask
    task automatic do_reset();               step(0, 0, 0, 0, 0); endtask
    task automatic draw();
        put(4'd3); put(4'd7); put(4'd1); put(4'd9);
    endtask

    initial begin
        reset = 1'b0; numero = '0; insere = 0; fim = 0; out_ready = 0;

        // draw capture
        do_reset();
        draw();
        chk("sorteio_3719", 32'(sorteio), 32'h3719);
        chk("sorteio_ok", 32'(sorteio_ok), 32'd1);

        // single game streamed with ready held
        put(4'd2); put(4'd4); put(4'd6); put(4'd8);
        valid_cnt = 0; fimj_cnt = 0;
        cmd_fim();
        repeat (6) idle(1);
        chk("one_game_valid", 32'(valid_cnt), 32'd4);
        chk("one_game_fimj", 32'(fimj_cnt), 32'd1);
        chk("one_game_done", 32'({concluido, ocupado}), 32'b10);

        // overfill: sixth game rejected
        do_reset();
        draw();
        for (int g = 0; g < 6; g++)
            for (int k = 1; k <= 4; k++) put(4'(g + k));
        chk("full_jogos", 32'(jogos), 32'(MAXJ));
        valid_cnt = 0; fimj_cnt = 0;
        cmd_fim();
        repeat (25) idle(1);
        chk("full_valid", 32'(valid_cnt), 32'd20);
        chk("full_fimj", 32'(fimj_cnt), 32'd5);

        // partial game discarded on fim
        do_reset();
        draw();
        put(4'd1); put(4'd2); put(4'd3); put(4'd4);
        put(4'd5); put(4'd6);
        valid_cnt = 0;
        cmd_fim();
        chk("partial_erro", 32'(erro), 32'd1);
        repeat (8) idle(1);
        chk("partial_valid", 32'(valid_cnt), 32'd4);

        // back-pressure 1,0,0,1
        do_reset();
        draw();
        for (int k = 1; k <= 8; k++) put(4'(k + 2));
        step(0, 0, 1, 0, 1);
        for (int k = 0; k < 40; k++) idle(k % 4 == 0 || k % 4 == 3);

        // zero and repeated entries
        do_reset();
        draw();
        put(4'd0);
        chk("zero_erro", 32'(erro), 32'd1);
        put(4'd4); put(4'd4);
        chk("dup_erro", 32'(erro), 32'(DUP_EN));
        put(4'd5); put(4'd6); put(4'd7);

        // reset while streaming
        cmd_fim();
        idle(1);
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sorteio_ok", 32'(sorteio_ok), 32'd0);
        idle(1);

        // random traffic
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int c = 0; c < 120; c++)
                step(4'($urandom_range(0, 15)), $urandom_range(0, 99) < 60,
                     $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70,
                     $urandom_range(0, 199) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
